i2c_txn_sequencer: RTL and testbench

Round-robin transaction sequencer that lets several on-chip requesters share one byte-level I2C master core. A granted requester posts one complete transfer: 7-bit address, direction, and 1–16 bytes. The block breaks it into the core's command stream (START, address write, data writes or reads with ACK/NAK, STOP) and handles one command in flight at a time. It sits between the requester fabric and the I2C master command port, and is exercised against the I2C slave BFM.

---
 rtl/i2c_pkg.sv | 7 +
 rtl/i2c_txn_sequencer_if.sv | 30 +++
 rtl/i2c_rr_arbiter.sv | 22 ++
 rtl/i2c_txn_sequencer.sv | 110 +++++++++++
 tb/tb_i2c_txn_sequencer.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared command, error and state encodings plus the address width for the I2C transaction sequencer
package i2c_pkg;
  localparam int I2C_ADDR_W = 7;
  typedef enum logic [2:0] {CMD_START, CMD_STOP, CMD_WRITE, CMD_READ_ACK, CMD_READ_NAK} cmd_e;
  typedef enum logic [1:0] {ERR_OK, ERR_ADDR, ERR_DATA, ERR_AL} err_e;
  typedef enum logic [2:0] {S_IDLE, S_START, S_ADDR, S_WDATA, S_RDATA, S_STOP, S_DONE} state_e;
endpackage

// File: rtl/i2c_txn_sequencer_if.sv
// i2c_txn_sequencer_if: requester-side transfer posting and I2C master command/response bus; master = sequencer view, slave = requesters plus core view
interface i2c_txn_sequencer_if #(parameter int NUM_REQ = 2, parameter int LEN_W = 4);
  logic [NUM_REQ-1:0]       req_i;
  logic [7*NUM_REQ-1:0]     addr_i;
  logic [NUM_REQ-1:0]       rw_i;
  logic [LEN_W*NUM_REQ-1:0] len_i;
  logic [8*NUM_REQ-1:0]     wdata_i;
  logic [NUM_REQ-1:0]       gnt_o;
  logic                     wdata_rd_o;
  logic [7:0]               rdata_o;
  logic                     rdata_valid_o;
  logic                     done_o;
  logic [1:0]               err_o;
  logic [2:0]               cmd_o;
  logic [7:0]               cmd_data_o;
  logic                     cmd_valid_o;
  logic                     cmd_ready_i;
  logic                     rsp_valid_i;
  logic                     rsp_nak_i;
  logic                     rsp_al_i;
  logic [7:0]               rsp_data_i;
  modport master (
    input  req_i, addr_i, rw_i, len_i, wdata_i, cmd_ready_i, rsp_valid_i, rsp_nak_i, rsp_al_i, rsp_data_i,
    output gnt_o, wdata_rd_o, rdata_o, rdata_valid_o, done_o, err_o, cmd_o, cmd_data_o, cmd_valid_o
  );
  modport slave (
    output req_i, addr_i, rw_i, len_i, wdata_i, cmd_ready_i, rsp_valid_i, rsp_nak_i, rsp_al_i, rsp_data_i,
    input  gnt_o, wdata_rd_o, rdata_o, rdata_valid_o, done_o, err_o, cmd_o, cmd_data_o, cmd_valid_o
  );
endinterface

// File: rtl/i2c_rr_arbiter.sv
// i2c_rr_arbiter: combinational round-robin pick; req/ptr in, one-hot gnt of first requester at or after ptr out
module i2c_rr_arbiter #(parameter int NUM_REQ = 2) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt
);
  localparam int PW = $clog2(NUM_REQ);
  logic [PW-1:0] j;
  logic found;
  always_comb begin
    gnt = '0;
    j = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = PW'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[j]) begin
        gnt[j] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: round-robin sequencer turning posted transfers into START/addr/data/STOP core commands; clk_i, rst_i (sync active-low), bus (master modport)
module i2c_txn_sequencer import i2c_pkg::*; #(parameter int NUM_REQ = 2, parameter int LEN_W = 4) (
  input logic clk_i,
  input logic rst_i,
  i2c_txn_sequencer_if.master bus
);
  localparam int PW = $clog2(NUM_REQ);
  state_e st;
  err_e code;
  logic [PW-1:0] rr_ptr, gidx, aidx;
  logic [NUM_REQ-1:0] arb;
  logic [I2C_ADDR_W-1:0] addr;
  logic rw;
  logic [LEN_W-1:0] cnt;
  logic take;
  logic [I2C_ADDR_W-1:0] addr_a [NUM_REQ];
  logic [LEN_W-1:0] len_a [NUM_REQ];
  logic [7:0] wd_a [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g] = bus.addr_i[g*I2C_ADDR_W +: I2C_ADDR_W];
    assign len_a[g] = bus.len_i[g*LEN_W +: LEN_W];
    assign wd_a[g] = bus.wdata_i[g*8 +: 8];
  end
  i2c_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (.req(bus.req_i), .ptr(rr_ptr), .gnt(arb));
  always_comb begin
    aidx = '0;
    for (int i = 0; i < NUM_REQ; i++) if (arb[i]) aidx = PW'(i);
  end
  // a response landing on the handshake cycle itself counts as accepted
  assign take = bus.rsp_valid_i && (!bus.cmd_valid_o || bus.cmd_ready_i);
  assign bus.wdata_rd_o = bus.cmd_valid_o && bus.cmd_ready_i && st == S_WDATA;
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      st <= S_IDLE;
      code <= ERR_OK;
      rr_ptr <= '0;
      gidx <= '0;
      addr <= '0;
      rw <= 1'b0;
      cnt <= '0;
      bus.gnt_o <= '0;
      bus.cmd_o <= '0;
      bus.cmd_data_o <= '0;
      bus.cmd_valid_o <= 1'b0;
      bus.rdata_o <= '0;
      bus.rdata_valid_o <= 1'b0;
      bus.done_o <= 1'b0;
      bus.err_o <= '0;
    end else begin
      bus.done_o <= 1'b0;
      bus.err_o <= '0;
      bus.rdata_valid_o <= 1'b0;
      if (bus.cmd_valid_o && bus.cmd_ready_i) bus.cmd_valid_o <= 1'b0;
      if (st == S_IDLE || st == S_DONE) begin
        st <= S_IDLE;
        if (|bus.req_i) begin
          st <= S_START;
          bus.gnt_o <= arb;
          gidx <= aidx;
          addr <= addr_a[aidx];
          rw <= bus.rw_i[aidx];
          cnt <= len_a[aidx];
          code <= ERR_OK;
          bus.cmd_o <= CMD_START;
          bus.cmd_valid_o <= 1'b1;
        end
      end else if (take && (bus.rsp_al_i || st == S_STOP)) begin
        // lost arbitration means the bus is not ours, so finish without a STOP
        st <= S_DONE;
        bus.done_o <= 1'b1;
        bus.err_o <= bus.rsp_al_i ? ERR_AL : code;
        bus.gnt_o <= '0;
        rr_ptr <= (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
      end else if (take) begin
        bus.cmd_valid_o <= 1'b1;
        case (st)
          S_START: begin
            st <= S_ADDR;
            bus.cmd_o <= CMD_WRITE;
            bus.cmd_data_o <= {addr, rw};
          end
          S_ADDR: begin
            st <= bus.rsp_nak_i ? S_STOP : rw ? S_RDATA : S_WDATA;
            code <= bus.rsp_nak_i ? ERR_ADDR : ERR_OK;
            bus.cmd_o <= bus.rsp_nak_i ? CMD_STOP : !rw ? CMD_WRITE : cnt == '0 ? CMD_READ_NAK : CMD_READ_ACK;
            bus.cmd_data_o <= wd_a[gidx];
          end
          S_WDATA: begin
            st <= (bus.rsp_nak_i || cnt == '0) ? S_STOP : S_WDATA;
            code <= bus.rsp_nak_i ? ERR_DATA : ERR_OK;
            bus.cmd_o <= (bus.rsp_nak_i || cnt == '0) ? CMD_STOP : CMD_WRITE;
            bus.cmd_data_o <= wd_a[gidx];
            cnt <= cnt - 1'b1;
          end
          S_RDATA: begin
            bus.rdata_o <= bus.rsp_data_i;
            bus.rdata_valid_o <= 1'b1;
            st <= cnt == '0 ? S_STOP : S_RDATA;
            bus.cmd_o <= cnt == '0 ? CMD_STOP : cnt == LEN_W'(1) ? CMD_READ_NAK : CMD_READ_ACK;
            cnt <= cnt - 1'b1;
          end
          default: begin
            st <= S_IDLE;
            bus.cmd_valid_o <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb_i2c_txn_sequencer: scoreboard bench with an I2C master-core/slave model driving the sequencer
module tb_i2c_txn_sequencer;
  import i2c_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  i2c_txn_sequencer_if #(.NUM_REQ(2), .LEN_W(4)) bus ();
  i2c_txn_sequencer #(.NUM_REQ(2), .LEN_W(4)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  int pass_cnt = 0;
  int total = 0;
  int wcnt = 0;
  int al_on = 0;
  int wnum = 0;
  bit first, pend, p_nak, p_al;
  logic [7:0] p_data;
  logic [6:0] bfm_addr = 7'h22;
  logic [10:0] exp_cmd[$], obs_cmd[$];
  logic [7:0] exp_rd[$], obs_rd[$], rx[$], tx[$], wq0[$], wq1[$];
  logic [3:0] obs_done[$];
  initial forever begin
    @(posedge clk);
    #1;
    bus.rsp_valid_i = pend;
    bus.rsp_nak_i = pend & p_nak;
    bus.rsp_al_i = pend & p_al;
    bus.rsp_data_i = pend ? p_data : 8'h00;
    pend = 1'b0;
    @(negedge clk);
    if (bus.done_o) obs_done.push_back({bus.gnt_o, bus.err_o});
    if (bus.rdata_valid_o) obs_rd.push_back(bus.rdata_o);
    if (bus.wdata_rd_o) begin
      wcnt++;
      if (bus.gnt_o[0] && wq0.size() > 0) void'(wq0.pop_front());
      if (bus.gnt_o[1] && wq1.size() > 0) void'(wq1.pop_front());
    end
    bus.wdata_i = {wq1.size() > 0 ? wq1[0] : 8'h00, wq0.size() > 0 ? wq0[0] : 8'h00};
    if (bus.cmd_valid_o && bus.cmd_ready_i) begin
      obs_cmd.push_back({bus.cmd_o, bus.cmd_o == CMD_WRITE ? bus.cmd_data_o : 8'h00});
      pend = 1'b1; p_nak = 1'b0; p_al = 1'b0; p_data = 8'h00;
      case (bus.cmd_o)
        CMD_START: first = 1'b1;
        CMD_WRITE: begin
          if (first) begin
            p_nak = bus.cmd_data_o[7:1] != bfm_addr;
            first = 1'b0;
            wnum = 0;
          end else begin
            wnum++;
            p_al = (wnum == al_on);
            rx.push_back(bus.cmd_data_o);
          end
        end
        CMD_READ_ACK, CMD_READ_NAK: p_data = tx.size() > 0 ? tx.pop_front() : 8'hFF;
        default: ;
      endcase
    end
  end
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.gnt_o !== 2'b00) $display("FAIL reset_gnt got %b want 00", bus.gnt_o); else pass_cnt++;
    total++; if ({bus.cmd_valid_o, bus.cmd_o, bus.cmd_data_o} !== 12'h0) $display("FAIL reset_cmd got %b/%h/%h want 0/0/00", bus.cmd_valid_o, bus.cmd_o, bus.cmd_data_o); else pass_cnt++;
    total++; if ({bus.done_o, bus.err_o, bus.wdata_rd_o} !== 4'h0) $display("FAIL reset_done got done=%b err=%0d wrd=%b want 0", bus.done_o, bus.err_o, bus.wdata_rd_o); else pass_cnt++;
    total++; if ({bus.rdata_valid_o, bus.rdata_o} !== 9'h0) $display("FAIL reset_rdata got %b/%h want 0/00", bus.rdata_valid_o, bus.rdata_o); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_write();
    exp_cmd = '{{CMD_START, 8'h00}, {CMD_WRITE, 8'h44}, {CMD_WRITE, 8'hA5}, {CMD_WRITE, 8'h5A}, {CMD_WRITE, 8'h3C}, {CMD_STOP, 8'h00}};
    obs_cmd.delete(); obs_done.delete(); rx.delete(); wcnt = 0;
    wq0 = '{8'hA5, 8'h5A, 8'h3C};
    bus.addr_i[6:0] = 7'h22; bus.rw_i[0] = 1'b0; bus.len_i[3:0] = 4'd2; bus.req_i[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (bus.gnt_o != 0) break; end
    total++; if (bus.gnt_o !== 2'b01) $display("FAIL wr_gnt got %b want 01", bus.gnt_o); else pass_cnt++;
    total++; if (!(bus.cmd_valid_o === 1'b1 && bus.cmd_o === CMD_START)) $display("FAIL wr_start_with_gnt got valid=%b cmd=%0d want 1/0", bus.cmd_valid_o, bus.cmd_o); else pass_cnt++;
    bus.req_i[0] = 1'b0;
    for (int k = 0; k < 300 && obs_done.size() < 1; k++) @(posedge clk);
    total++; if (obs_done.size() != 1) $display("FAIL wr_done_count got %0d want 1", obs_done.size()); else pass_cnt++;
    total++; if (obs_done[0] !== 4'h0) $display("FAIL wr_done got gnt/err %h want 0", obs_done[0]); else pass_cnt++;
    total++; if (obs_cmd.size() != exp_cmd.size()) $display("FAIL wr_cmd_count got %0d want %0d", obs_cmd.size(), exp_cmd.size()); else pass_cnt++;
    foreach (exp_cmd[i]) begin
      total++; if (i >= obs_cmd.size() || obs_cmd[i] !== exp_cmd[i]) $display("FAIL wr_cmd%0d got %h want %h", i, i < obs_cmd.size() ? obs_cmd[i] : 11'h7FF, exp_cmd[i]); else pass_cnt++;
    end
    total++; if (wcnt != 3) $display("FAIL wr_wdata_rd got %0d want 3", wcnt); else pass_cnt++;
    total++; if (rx != '{8'hA5, 8'h5A, 8'h3C}) $display("FAIL wr_bfm_rx got %p want A5 5A 3C", rx); else pass_cnt++;
  endtask
  task automatic test_read();
    exp_cmd = '{{CMD_START, 8'h00}, {CMD_WRITE, 8'h45}, {CMD_READ_ACK, 8'h00}, {CMD_READ_NAK, 8'h00}, {CMD_STOP, 8'h00}};
    exp_rd = '{8'h11, 8'h22};
    obs_cmd.delete(); obs_done.delete(); obs_rd.delete();
    tx = '{8'h11, 8'h22};
    bus.addr_i[13:7] = 7'h22; bus.rw_i[1] = 1'b1; bus.len_i[7:4] = 4'd1; bus.req_i[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (bus.gnt_o != 0) break; end
    total++; if (bus.gnt_o !== 2'b10) $display("FAIL rd_gnt got %b want 10", bus.gnt_o); else pass_cnt++;
    bus.req_i[1] = 1'b0;
    for (int k = 0; k < 300 && obs_done.size() < 1; k++) @(posedge clk);
    total++; if (obs_done.size() != 1 || obs_done[0] !== 4'h0) $display("FAIL rd_done got n=%0d gnt/err %h want 1/0", obs_done.size(), obs_done.size() > 0 ? obs_done[0] : 4'hF); else pass_cnt++;
    total++; if (obs_cmd.size() != exp_cmd.size()) $display("FAIL rd_cmd_count got %0d want %0d", obs_cmd.size(), exp_cmd.size()); else pass_cnt++;
    foreach (exp_cmd[i]) begin
      total++; if (i >= obs_cmd.size() || obs_cmd[i] !== exp_cmd[i]) $display("FAIL rd_cmd%0d got %h want %h", i, i < obs_cmd.size() ? obs_cmd[i] : 11'h7FF, exp_cmd[i]); else pass_cnt++;
    end
    while (exp_rd.size() > 0) begin
      logic [7:0] e;
      e = exp_rd.pop_front();
      total++; if (obs_rd.size() == 0) $display("FAIL rd_data missing want %h", e);
      else begin logic [7:0] o; o = obs_rd.pop_front(); if (o !== e) $display("FAIL rd_data got %h want %h", o, e); else pass_cnt++; end
    end
  endtask
  task automatic test_back_to_back();
    int gap;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    obs_done.delete(); rx.delete();
    wq0 = '{8'h11, 8'h12}; wq1 = '{8'h21};
    bus.addr_i = {7'h22, 7'h22}; bus.rw_i = 2'b00; bus.len_i = 8'h00; bus.req_i = 2'b11;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (bus.gnt_o != 0) break; end
    total++; if (bus.gnt_o !== 2'b01) $display("FAIL rr_first got %b want 01", bus.gnt_o); else pass_cnt++;
    for (int k = 0; k < 300 && obs_done.size() < 1; k++) @(posedge clk);
    gap = 0;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (bus.gnt_o != 0) break; gap++; end
    total++; if (bus.gnt_o !== 2'b10) $display("FAIL rr_second got %b want 10", bus.gnt_o); else pass_cnt++;
    total++; if (gap != 0) $display("FAIL rr_regrant_gap got %0d want 0", gap); else pass_cnt++;
    bus.req_i[1] = 1'b0;
    for (int k = 0; k < 300 && obs_done.size() < 2; k++) @(posedge clk);
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (bus.gnt_o != 0) break; end
    total++; if (bus.gnt_o !== 2'b01) $display("FAIL rr_third got %b want 01", bus.gnt_o); else pass_cnt++;
    bus.req_i[0] = 1'b0;
    for (int k = 0; k < 300 && obs_done.size() < 3; k++) @(posedge clk);
    total++; if (obs_done.size() != 3) $display("FAIL rr_done_count got %0d want 3", obs_done.size()); else pass_cnt++;
    total++; if (rx != '{8'h11, 8'h21, 8'h12}) $display("FAIL rr_bfm_rx got %p want 11 21 12", rx); else pass_cnt++;
  endtask
  task automatic test_addr_nak();
    exp_cmd = '{{CMD_START, 8'h00}, {CMD_WRITE, 8'h60}, {CMD_STOP, 8'h00}};
    obs_cmd.delete(); obs_done.delete(); wcnt = 0;
    wq0 = '{8'h77};
    bus.addr_i[6:0] = 7'h30; bus.rw_i[0] = 1'b0; bus.len_i[3:0] = 4'd0; bus.req_i[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (bus.gnt_o != 0) break; end
    bus.req_i[0] = 1'b0;
    for (int k = 0; k < 300 && obs_done.size() < 1; k++) @(posedge clk);
    total++; if (obs_done.size() != 1 || obs_done[0] !== {2'b00, 2'd1}) $display("FAIL nak_done got n=%0d gnt/err %h want 1/1", obs_done.size(), obs_done.size() > 0 ? obs_done[0] : 4'hF); else pass_cnt++;
    total++; if (obs_cmd.size() != exp_cmd.size()) $display("FAIL nak_cmd_count got %0d want %0d", obs_cmd.size(), exp_cmd.size()); else pass_cnt++;
    foreach (exp_cmd[i]) begin
      total++; if (i >= obs_cmd.size() || obs_cmd[i] !== exp_cmd[i]) $display("FAIL nak_cmd%0d got %h want %h", i, i < obs_cmd.size() ? obs_cmd[i] : 11'h7FF, exp_cmd[i]); else pass_cnt++;
    end
    total++; if (wcnt != 0) $display("FAIL nak_wdata_rd got %0d want 0", wcnt); else pass_cnt++;
  endtask
  task automatic test_al();
    exp_cmd = '{{CMD_START, 8'h00}, {CMD_WRITE, 8'h44}, {CMD_WRITE, 8'hB1}, {CMD_WRITE, 8'hB2}};
    obs_cmd.delete(); obs_done.delete(); wcnt = 0; al_on = 2;
    wq0 = '{8'hB1, 8'hB2, 8'hB3};
    bus.addr_i[6:0] = 7'h22; bus.rw_i[0] = 1'b0; bus.len_i[3:0] = 4'd2; bus.req_i[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (bus.gnt_o != 0) break; end
    bus.req_i[0] = 1'b0;
    for (int k = 0; k < 300 && obs_done.size() < 1; k++) @(posedge clk);
    repeat (4) @(negedge clk);
    al_on = 0;
    total++; if (obs_done.size() != 1 || obs_done[0] !== {2'b00, 2'd3}) $display("FAIL al_done got n=%0d gnt/err %h want 1/3", obs_done.size(), obs_done.size() > 0 ? obs_done[0] : 4'hF); else pass_cnt++;
    total++; if (obs_cmd.size() != exp_cmd.size()) $display("FAIL al_cmd_count got %0d want %0d", obs_cmd.size(), exp_cmd.size()); else pass_cnt++;
    foreach (exp_cmd[i]) begin
      total++; if (i >= obs_cmd.size() || obs_cmd[i] !== exp_cmd[i]) $display("FAIL al_cmd%0d got %h want %h", i, i < obs_cmd.size() ? obs_cmd[i] : 11'h7FF, exp_cmd[i]); else pass_cnt++;
    end
    total++; if (bus.gnt_o !== 2'b00) $display("FAIL al_gnt got %b want 00", bus.gnt_o); else pass_cnt++;
  endtask
  task automatic test_reset_mid();
    obs_cmd.delete(); obs_done.delete();
    wq0 = '{8'hC7};
    bus.cmd_ready_i = 1'b0;
    bus.addr_i[6:0] = 7'h22; bus.rw_i[0] = 1'b0; bus.len_i[3:0] = 4'd0; bus.req_i[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (bus.cmd_valid_o) break; end
    repeat (2) @(negedge clk);
    total++; if (bus.cmd_valid_o !== 1'b1) $display("FAIL rstmid_stall got valid=%b want 1", bus.cmd_valid_o); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    total++; if ({bus.gnt_o, bus.cmd_valid_o, bus.cmd_o, bus.cmd_data_o, bus.done_o, bus.err_o, bus.rdata_valid_o, bus.rdata_o, bus.wdata_rd_o} !== 33'h0)
      $display("FAIL rstmid_outputs got gnt=%b v=%b cmd=%0d d=%h done=%b err=%0d rv=%b want all 0", bus.gnt_o, bus.cmd_valid_o, bus.cmd_o, bus.cmd_data_o, bus.done_o, bus.err_o, bus.rdata_valid_o); else pass_cnt++;
    total++; if (obs_cmd.size() != 0) $display("FAIL rstmid_no_cmd got %0d want 0", obs_cmd.size()); else pass_cnt++;
    rst = 1'b1;
    bus.cmd_ready_i = 1'b1;
    exp_cmd = '{{CMD_START, 8'h00}, {CMD_WRITE, 8'h44}, {CMD_WRITE, 8'hC7}, {CMD_STOP, 8'h00}};
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (bus.gnt_o != 0) break; end
    bus.req_i[0] = 1'b0;
    for (int k = 0; k < 300 && obs_done.size() < 1; k++) @(posedge clk);
    total++; if (obs_done.size() != 1 || obs_done[0] !== 4'h0) $display("FAIL rstmid_done got n=%0d gnt/err %h want 1/0", obs_done.size(), obs_done.size() > 0 ? obs_done[0] : 4'hF); else pass_cnt++;
    foreach (exp_cmd[i]) begin
      total++; if (i >= obs_cmd.size() || obs_cmd[i] !== exp_cmd[i]) $display("FAIL rstmid_cmd%0d got %h want %h", i, i < obs_cmd.size() ? obs_cmd[i] : 11'h7FF, exp_cmd[i]); else pass_cnt++;
    end
  endtask
  initial begin
    bus.req_i = '0; bus.addr_i = '0; bus.rw_i = '0; bus.len_i = '0; bus.wdata_i = '0;
    bus.cmd_ready_i = 1'b1; bus.rsp_valid_i = 1'b0; bus.rsp_nak_i = 1'b0; bus.rsp_al_i = 1'b0; bus.rsp_data_i = '0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_addr_nak();
    test_al();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
